ocl_fifo_bank: RTL

- Parametrised successor to the single-FIFO OCL register endpoint: NUM_CH independent FIFOs, each DATA_W wide and DEPTH deep, behind one register-mapped read/write strobe interface.
- Sits behind the AXI-L OCL slave logic in the CL top, which drives the write strobe and read request and forwards the read response.
- Adds per-channel status/control registers, sticky error flags, flush, and not-empty indication.

---
 rtl/ocl_fifo_bank.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/ocl_fifo_bank.sv
// Bank of NUM_CH register-mapped FIFOs with per-channel STATUS/CTRL and sticky errors.
// Optional watermark register and interrupt level enabled by OCL_FIFO_BANK_WM_IRQ_EN.
module ocl_fifo_bank #(
  parameter int unsigned NUM_CH       = 4,
  parameter int unsigned DEPTH        = 16,
  parameter int unsigned DATA_W       = 32,
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0100,
  parameter logic [31:0] UNIMPL_VALUE = 32'hDEAD_BEEF
) (
  input  logic              clk_main_a0,
  input  logic              rst_main,
  input  logic              wr_en,
  input  logic [31:0]       wr_addr,
  input  logic [31:0]       wr_data,
  output logic              wr_err,
  input  logic              rd_req,
  output logic              rd_req_ready,
  input  logic [31:0]       rd_addr,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [31:0]       rd_data,
  output logic [1:0]        rd_resp,
  output logic [NUM_CH-1:0] ch_not_empty,
  output logic [NUM_CH-1:0] fifo_wm_irq
);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [31:0] SPAN  = 32'(16 * NUM_CH);
`ifdef OCL_FIFO_BANK_WM_IRQ_EN
  localparam logic WM_EN = 1'b1;
`else
  localparam logic WM_EN = 1'b0;
`endif

  logic [DATA_W-1:0] r_mem [NUM_CH][DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr [NUM_CH];
  logic [PTR_W-1:0]  r_rd_ptr [NUM_CH];
  logic [CNT_W-1:0]  r_cnt [NUM_CH];
  logic [15:0]       r_wm [NUM_CH];
  logic [NUM_CH-1:0] r_ovf, r_unf, r_not_empty, r_wm_irq;
  logic              r_rd_valid, r_wr_err;
  logic [31:0]       r_rd_data;
  logic [1:0]        r_rd_resp;

  // Address decode; low two address bits fall out of the offset arithmetic
  logic [31:0]     w_wr_off, w_rd_off;
  logic [CH_W-1:0] w_wr_ch, w_rd_ch;
  logic [1:0]      w_wr_reg, w_rd_reg;
  logic            w_wr_map, w_rd_map, w_rd_acc;

  assign w_wr_off = wr_addr - BASE_ADDR;
  assign w_rd_off = rd_addr - BASE_ADDR;
  assign w_wr_ch  = CH_W'(w_wr_off >> 4);
  assign w_rd_ch  = CH_W'(w_rd_off >> 4);
  assign w_wr_reg = w_wr_off[3:2];
  assign w_rd_reg = w_rd_off[3:2];
  assign w_wr_map = (wr_addr >= BASE_ADDR) && (w_wr_off < SPAN) && ((w_wr_reg != 2'd3) || WM_EN);
  assign w_rd_map = (rd_addr >= BASE_ADDR) && (w_rd_off < SPAN) && ((w_rd_reg != 2'd3) || WM_EN);
  assign w_rd_acc = rd_req && !r_rd_valid;

  logic [NUM_CH-1:0] w_push, w_pop, w_full, w_empty, w_flush, w_clr, w_wm_wr;
  logic [CNT_W-1:0]  w_cnt_nxt [NUM_CH];
  logic [15:0]       w_wm_nxt [NUM_CH];

  // Per-channel events, all judged on pre-cycle state
  always_comb begin
    w_push  = '0;
    w_pop   = '0;
    w_flush = '0;
    w_clr   = '0;
    w_wm_wr = '0;
    w_full  = '0;
    w_empty = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      w_cnt_nxt[c] = r_cnt[c];
      w_wm_nxt[c]  = r_wm[c];
      w_full[c]    = (r_cnt[c] == CNT_W'(DEPTH));
      w_empty[c]   = (r_cnt[c] == '0);
      if (wr_en && w_wr_map && (w_wr_ch == CH_W'(c))) begin
        w_push[c]  = (w_wr_reg == 2'd0);
        w_flush[c] = (w_wr_reg == 2'd2) && wr_data[0];
        w_clr[c]   = (w_wr_reg == 2'd2) && wr_data[1];
        w_wm_wr[c] = (w_wr_reg == 2'd3);
      end
      w_pop[c] = w_rd_acc && w_rd_map && (w_rd_ch == CH_W'(c)) && (w_rd_reg == 2'd0);
      if (w_flush[c])
        w_cnt_nxt[c] = '0;
      else
        w_cnt_nxt[c] = r_cnt[c] + CNT_W'(w_push[c] && !w_full[c]) - CNT_W'(w_pop[c] && !w_empty[c]);
      if (w_wm_wr[c])
        w_wm_nxt[c] = wr_data[15:0];
    end
  end

  always_ff @(posedge clk_main_a0) begin
    for (int c = 0; c < NUM_CH; c++)
      if (w_push[c] && !w_full[c])
        r_mem[c][r_wr_ptr[c]] <= wr_data[DATA_W-1:0];
  end

  // Channel state; a new error beats a same-cycle sticky clear
  always_ff @(posedge clk_main_a0 or posedge rst_main) begin
    if (rst_main) begin
      for (int c = 0; c < NUM_CH; c++) begin
        r_wr_ptr[c] <= '0;
        r_rd_ptr[c] <= '0;
        r_cnt[c]    <= '0;
        r_wm[c]     <= 16'(DEPTH);
      end
      r_ovf       <= '0;
      r_unf       <= '0;
      r_not_empty <= '0;
      r_wm_irq    <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (w_flush[c]) begin
          r_wr_ptr[c] <= '0;
          r_rd_ptr[c] <= '0;
        end else begin
          if (w_push[c] && !w_full[c])  r_wr_ptr[c] <= r_wr_ptr[c] + PTR_W'(1);
          if (w_pop[c] && !w_empty[c])  r_rd_ptr[c] <= r_rd_ptr[c] + PTR_W'(1);
        end
        r_cnt[c]       <= w_cnt_nxt[c];
        r_wm[c]        <= w_wm_nxt[c];
        r_ovf[c]       <= (w_push[c] && w_full[c]) || (r_ovf[c] && !w_clr[c]);
        r_unf[c]       <= (w_pop[c] && w_empty[c]) || (r_unf[c] && !w_clr[c]);
        r_not_empty[c] <= (w_cnt_nxt[c] != '0);
        r_wm_irq[c]    <= WM_EN && (w_wm_nxt[c] != 16'd0) && (16'(w_cnt_nxt[c]) >= w_wm_nxt[c]);
      end
    end
  end

  logic [31:0] w_rdata;
  logic [1:0]  w_rresp;

  always_comb begin
    w_rdata = UNIMPL_VALUE;
    w_rresp = 2'b00;
    if (w_rd_map) begin
      case (w_rd_reg)
        2'd0: begin
          if (w_empty[w_rd_ch]) begin
            w_rdata = 32'd0;
            w_rresp = 2'b10;
          end else begin
            w_rdata = 32'(r_mem[w_rd_ch][r_rd_ptr[w_rd_ch]]);
          end
        end
        2'd1: w_rdata = {w_full[w_rd_ch], w_empty[w_rd_ch], r_ovf[w_rd_ch], r_unf[w_rd_ch],
                         r_wm_irq[w_rd_ch], 11'd0, 16'(r_cnt[w_rd_ch])};
        2'd2: w_rdata = 32'd0;
        default: w_rdata = 32'(r_wm[w_rd_ch]);
      endcase
    end
  end

  // Single outstanding read response plus write error pulse
  always_ff @(posedge clk_main_a0 or posedge rst_main) begin
    if (rst_main) begin
      r_rd_valid <= 1'b0;
      r_rd_data  <= 32'd0;
      r_rd_resp  <= 2'b00;
      r_wr_err   <= 1'b0;
    end else begin
      if (w_rd_acc) begin
        r_rd_valid <= 1'b1;
        r_rd_data  <= w_rdata;
        r_rd_resp  <= w_rresp;
      end else if (r_rd_valid && rd_ready) begin
        r_rd_valid <= 1'b0;
      end
      r_wr_err <= wr_en && (!w_wr_map || ((w_wr_reg == 2'd0) && w_full[w_wr_ch]));
    end
  end

  assign wr_err       = r_wr_err;
  assign rd_valid     = r_rd_valid;
  assign rd_req_ready = !r_rd_valid;
  assign rd_data      = r_rd_data;
  assign rd_resp      = r_rd_resp;
  assign ch_not_empty = r_not_empty;
  assign fifo_wm_irq  = r_wm_irq;
endmodule
